// File: rtl/rst_sync_pkg.sv
// Shared constants for the reset synchronizer: default and legal chain lengths,
// plus a helper used at elaboration time to reject illegal stage counts.
package rst_sync_pkg;

    // Two flops is the usual minimum for metastability settling at the release edge.
    localparam int unsigned RST_SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned RST_SYNC_STAGES_MIN     = 2;
    localparam int unsigned RST_SYNC_STAGES_MAX     = 8;

    // True when a requested chain length is within the supported range.
    function automatic bit stages_legal(input int unsigned stages);
        return (stages >= RST_SYNC_STAGES_MIN) && (stages <= RST_SYNC_STAGES_MAX);
    endfunction

endpackage : rst_sync_pkg

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts rst_n_o asynchronously when rst_n_i falls and
// releases it synchronously to clk_i after STAGES rising edges with rst_n_i high.
// A constant 1 enters stage 0 and walks down the chain; rst_n_o is the last
// flop's Q with nothing combinational after it, so the released reset is glitch-free.
module rst_sync
    import rst_sync_pkg::*;
#(
    parameter int unsigned STAGES = RST_SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_o
);

    // Reject illegal chain lengths when the design is elaborated.
    generate
        if (!stages_legal(STAGES)) begin : g_bad_stages
            $error("rst_sync: STAGES must be in 2..8");
        end
    endgenerate

    // Synchronizer chain; bit 0 is the first flop. Kept adjacent and unretimed.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Asynchronous clear on rst_n_i low; otherwise shift a 1 in from the bottom.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[STAGES-1];

endmodule : rst_sync

// File: tb/tb_rst_sync.sv
// Bench for rst_sync: a 2-stage and a 4-stage instance share clock and reset.
// Time unit is 100 ps, so the 5 ns clock has rising edges at 50, 100, 150 ...
`timescale 100ps/100ps
module tb_rst_sync;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b1;
    logic rst_n = 1'b0;
    logic out2;
    logic out4;

    always #25 clk = ~clk;

    rst_sync #(.STAGES(2)) dut2 (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .rst_n_o(out2)
    );

    rst_sync #(.STAGES(4)) dut4 (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .rst_n_o(out4)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t: got %b want %b", name, idx, $time, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d edges want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   t;      // absolute time, 100 ps units
        bit   drive;  // 1: drive rst_n, 0: check outputs
        logic rst;    // value driven when drive=1
        logic e2;     // expected rst_n_o, STAGES=2
        logic e4;     // expected rst_n_o, STAGES=4
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int t, input bit drive, input logic rst,
                                input logic e2, input logic e4);
        vec_t v;
        v.t = t; v.drive = drive; v.rst = rst; v.e2 = e2; v.e4 = e4;
        return v;
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int first2;
        int first4;

        // Power-up: low from t=0, released at 2 ns; 2-stage rises at 10 ns, not 5 ns.
        vecs.push_back(mk(   5, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(  20, 1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(  30, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(  60, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 110, 0, 1'b0, 1'b1, 1'b0));
        // Asynchronous assert at 13 ns, seen before the 15 ns edge.
        vecs.push_back(mk( 130, 1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 135, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 145, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 160, 0, 1'b0, 1'b0, 1'b0));
        // Release at 26 ns: 2-stage rises at 35 ns, 4-stage at 45 ns.
        vecs.push_back(mk( 260, 1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk( 270, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 310, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 360, 0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk( 410, 0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk( 460, 0, 1'b0, 1'b1, 1'b1));
        // 1 ns glitch 52..53 ns: immediate drop, release on 2nd/4th edge after (60/70 ns).
        vecs.push_back(mk( 520, 1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 522, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 530, 1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk( 535, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 560, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 610, 0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk( 660, 0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk( 710, 0, 1'b0, 1'b1, 1'b1));
        // Re-assert mid-release: release 77 ns, edge 80 ns, low again 81 ns, final release 87 ns.
        vecs.push_back(mk( 760, 1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 770, 1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk( 790, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 810, 1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 815, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 860, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 870, 1, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk( 910, 0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk( 960, 0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1010, 0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1060, 0, 1'b0, 1'b1, 1'b1));
        // Steady state.
        vecs.push_back(mk(1190, 0, 1'b0, 1'b1, 1'b1));

        // ---------------- table driver ----------------
        foreach (vecs[i]) begin
            int now;
            now = int'($time);
            if (vecs[i].t > now) #(vecs[i].t - now);
            if (vecs[i].drive) begin
                rst_n = vecs[i].rst;
            end else begin
                check_bit("out_s2", i, out2, vecs[i].e2);
                check_bit("out_s4", i, out4, vecs[i].e4);
            end
        end

        // ---------------- release exactly on a rising edge ----------------
        #(1220 - int'($time));
        rst_n = 1'b0;
        #10;
        check_bit("edge_rel_assert_s2", 0, out2, 1'b0);
        check_bit("edge_rel_assert_s4", 0, out4, 1'b0);
        #(1250 - int'($time));
        rst_n = 1'b1;
        first2 = 0;
        first4 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (first2 == 0 && out2 === 1'b1) first2 = k;
            if (first4 == 0 && out4 === 1'b1) first4 = k;
        end
        check_range("edge_rel_count_s2", first2, 2, 3);
        check_range("edge_rel_count_s4", first4, 4, 5);

        // Held high: both stay released across many cycles.
        repeat (20) @(negedge clk);
        check_bit("hold_s2", 0, out2, 1'b1);
        check_bit("hold_s4", 0, out4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rst_sync
